pingpong_bram_buf: RTL
======================

// Module: pingpong_bram_buf
// PURPOSE
//  Parametrised double-buffered (ping-pong) simple-dual-port buffer between a producer
//  (writes word-addressed data) and a consumer engine (reads byte-addressed data).
//  Two banks let the producer fill one bank while the consumer reads the other.
//  Bank ownership is passed by a wr_last/rd_done handshake. Reads are pipelined with a valid flag.
// PARAMETERS
//  DATA_W     32   data word width, bits
//  DEPTH      256  words per bank; power of two, >=4
//  RD_ADDR_W  20   consumer byte-address width
//  BYTE_SHIFT 2    rd word index = rd_addr >> BYTE_SHIFT
//  OUT_REG    1    1: extra output register, read latency 2; 0: latency 1
// PORTS
//  clk       in   1                clock, rising edge
//  rst_n     in   1                asynchronous active-low reset
//  wr_en     in   1                write strobe, honoured only when wr_ready=1
//  wr_addr   in   $clog2(DEPTH)    word address in current write bank
//  wr_data   in   DATA_W           write data
//  wr_last   in   1                qualified by wr_en: last word, so the write bank becomes full
//  wr_ready  out  1                current write bank is free
//  rd_en     in   1                read request, honoured only when rd_ready=1
//  rd_addr   in   RD_ADDR_W        byte address in current read bank
//  rd_done   in   1                consumer releases current read bank
//  rd_ready  out  1                current read bank is full (readable)
//  rd_data   out  DATA_W           read data
//  rd_valid  out  1                rd_data valid this cycle
//  rd_err    out  1                pulse aligned with rd_valid: address out of range
//  ovf       out  1                sticky: wr_en seen while wr_ready=0
// BEHAVIOUR
//  Reset: wr_ptr=rd_ptr=0, full[1:0]=0, rd_data=0, rd_valid=0, rd_err=0, ovf=0.
//    Memory contents are not reset.
//  wr_ready = !full[wr_ptr]; rd_ready = full[rd_ptr] (combinational from registered state).
//  Write: when wr_en & wr_ready, bank[wr_ptr][wr_addr] <= wr_data at the edge.
//    If wr_last is also set, full[wr_ptr] <= 1 and wr_ptr toggles.
//  wr_en & !wr_ready: no write, no state change, ovf <= 1 (cleared only by reset).
//  Read: when rd_en & rd_ready, idx = rd_addr >> BYTE_SHIFT.
//    If idx < DEPTH: data = bank[rd_ptr][idx]. Otherwise data = 0 and rd_err=1.
//    rd_valid/rd_err/rd_data appear 1+OUT_REG cycles after the request. One result per cycle,
//    fully pipelined. When not valid, rd_data holds 0.
//  rd_en & !rd_ready: ignored, no rd_valid.
//  rd_done & rd_ready: full[rd_ptr] <= 0 and rd_ptr toggles. Reads already in flight still complete
//    with the old bank's data. rd_done & !rd_ready: ignored.
//  rd_en and rd_done in the same cycle: the read is from the bank being released.
//  wr_last and rd_done in the same cycle act on different banks; both take effect.
//  Both banks full: wr_ready=0 until rd_done. Both banks empty: rd_ready=0.
//  wr_addr is always in range by width; no wrap logic is needed.
//    Pointers wrap 1->0 by toggling.
//  Reset asserted mid-operation: the pipeline is flushed, flags cleared, partial bank content is
//    discarded logically.
// STRUCTURE
//  Shared package: bank-pointer typedef (1 bit), OUT_REG latency constant, localparams
//    IDX_W=$clog2(DEPTH) and RD_LAT=1+OUT_REG.
//  Sub-module bram_bank_sdp (one instance per bank): registered-read SDP RAM with
//    ram_style="block", no reset on the array. The top level holds the pointers, full flags,
//    range check and valid pipeline.
// TESTING
//  1 Reset, then fill bank0 addr0..255 with data=addr, wr_last@255 -> wr_ready=1 (bank1), rd_ready=1.
//  2 Read rd_addr=0,4,...,1020 back-to-back -> rd_valid at +2 cycles (OUT_REG=1), rd_data=0..255 in order.
//  3 Fill bank1 while bank0 is still full -> wr_ready=0 after wr_last; extra wr_en -> ovf=1, bank0 data intact.
//  4 rd_addr=1024 (idx 256) -> rd_valid=1, rd_err=1, rd_data=0.
//  5 rd_en+rd_done same cycle at addr 8 -> returns bank0 word 2; next read returns bank1 data; wr_ready=1.
//  6 rst_n low mid-burst with reads in flight -> rd_valid=0 immediately; after release wr_ready=1, rd_ready=0, ovf=0.

Source files
------------

// File: rtl/pingpong_bram_buf_pkg.sv
// Shared types and constants for the ping-pong BRAM buffer.
// Defaults here mirror the top-level parameter defaults.
package pingpong_bram_buf_pkg;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_ptr_e;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;
  localparam int OUT_REG    = 1;
  localparam int IDX_W      = $clog2(DEPTH_DEF);
  localparam int RD_LAT     = 1 + OUT_REG;

  function automatic bank_ptr_e next_bank(input bank_ptr_e b);
    return (b == BANK0) ? BANK1 : BANK0;
  endfunction

endpackage

// File: rtl/bram_bank_sdp.sv
// Simple-dual-port RAM with registered read; the array is never reset so it maps to block RAM.
module bram_bank_sdp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pingpong_bram_buf.sv
// Double-buffered word-write / byte-addressed-read buffer. Bank ownership is handed over
// with wr_last (producer done) and rd_done (consumer done); reads are pipelined with a valid flag.
module pingpong_bram_buf
  import pingpong_bram_buf_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 256,
  parameter int RD_ADDR_W  = 20,
  parameter int BYTE_SHIFT = 2,
  parameter int OUT_REG    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_last,
  output logic                     wr_ready,
  input  logic                     rd_en,
  input  logic [RD_ADDR_W-1:0]     rd_addr,
  input  logic                     rd_done,
  output logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     rd_err,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  bank_ptr_e             wr_ptr, rd_ptr;
  logic [1:0]            full;
  logic                  wr_fire, rd_fire, rd_release;
  logic [RD_ADDR_W-1:0]  idx;
  logic                  in_range;
  logic [DATA_W-1:0]     bank_q [2];

  logic                  s1_valid, s1_err;
  bank_ptr_e             s1_bank;
  logic [DATA_W-1:0]     s1_data;

  assign wr_ready   = !full[wr_ptr];
  assign rd_ready   = full[rd_ptr];
  assign wr_fire    = wr_en && wr_ready;
  assign rd_fire    = rd_en && rd_ready;
  assign rd_release = rd_done && rd_ready;

  // Word index is in range when no bits above the bank's address width are set.
  assign idx      = rd_addr >> BYTE_SHIFT;
  assign in_range = (idx >> AW) == '0;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bram_bank_sdp #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
    ) u_bank (
      .clk   (clk),
      .we    (wr_fire && (wr_ptr == bank_ptr_e'(b))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (rd_fire && in_range && (rd_ptr == bank_ptr_e'(b))),
      .raddr (idx[AW-1:0]),
      .rdata (bank_q[b])
    );
  end

  // wr_last and rd_done always act on different banks, so both bit updates can coexist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= BANK0;
      rd_ptr <= BANK0;
      full   <= 2'b00;
      ovf    <= 1'b0;
    end else begin
      if (wr_en && !wr_ready) ovf <= 1'b1;
      if (wr_fire && wr_last) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= next_bank(wr_ptr);
      end
      if (rd_release) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= next_bank(rd_ptr);
      end
    end
  end

  // The bank used is captured with the request so in-flight reads survive a release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_bank  <= BANK0;
    end else begin
      s1_valid <= rd_fire;
      s1_err   <= rd_fire && !in_range;
      s1_bank  <= rd_ptr;
    end
  end

  assign s1_data = (s1_valid && !s1_err) ? bank_q[s1_bank] : '0;

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid <= 1'b0;
        rd_err   <= 1'b0;
        rd_data  <= '0;
      end else begin
        rd_valid <= s1_valid;
        rd_err   <= s1_err;
        rd_data  <= s1_data;
      end
    end
  end else begin : g_no_out_reg
    assign rd_valid = s1_valid;
    assign rd_err   = s1_err;
    assign rd_data  = s1_data;
  end

endmodule
